// File: rtl/game_sequencer.sv
// ============================================================================
// game_sequencer : top-level game controller (WAITING/SETUP/PLAYING/PAUSED/WON/LOST)
// Revision 1.0   : initial release
// ============================================================================
`default_nettype none

module game_sequencer #(
  parameter int NUM_MODULES   = 4,
  parameter int MAX_STRIKES   = 3,
  parameter int SETUP_TIMEOUT = 27000000,
  parameter int TO_W          = 25
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start_game,
  input  logic                   setup_complete,
  input  logic [NUM_MODULES-1:0] module_solved,
  input  logic                   strike,
  input  logic                   timer_expired,
  input  logic                   pause_toggle,
  output logic                   begin_setup,
  output logic                   begin_timer,
  output logic                   timer_hold,
  output logic [NUM_MODULES-1:0] solved_mask,
  output logic [2:0]             strike_count,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    S_WAITING = 3'b000,
    S_SETUP   = 3'b001,
    S_WON     = 3'b010,
    S_LOST    = 3'b011,
    S_PLAYING = 3'b100,
    S_PAUSED  = 3'b101
  } state_t;

  localparam logic [NUM_MODULES-1:0] C_ALL_SOLVED  = '1;
  localparam logic [TO_W-1:0]        C_TO_LAST     = TO_W'(SETUP_TIMEOUT - 1);
  localparam logic [2:0]             C_MAX_STRIKES = 3'(MAX_STRIKES);
  localparam logic [2:0]             C_LAST_STRIKE = 3'(MAX_STRIKES - 1);

  state_t                  r_state;
  logic [NUM_MODULES-1:0]  r_mask;
  logic [2:0]              r_strikes;
  logic [TO_W-1:0]         r_to_cnt;
  logic                    r_begin_setup;
  logic                    r_begin_timer;
  logic                    r_timer_hold;

  state_t                  w_state_nxt;
  logic [NUM_MODULES-1:0]  w_mask_nxt;
  logic [2:0]              w_strikes_nxt;
  logic [TO_W-1:0]         w_to_cnt_nxt;
  logic [NUM_MODULES-1:0]  w_solved_any;
  logic                    w_loss;
  logic                    w_win;

  assign w_solved_any = r_mask | module_solved;
  assign w_loss       = timer_expired | (strike & (r_strikes == C_LAST_STRIKE));
  assign w_win        = (w_solved_any == C_ALL_SOLVED);

  always_comb begin
    w_state_nxt   = r_state;
    w_mask_nxt    = r_mask;
    w_strikes_nxt = r_strikes;
    w_to_cnt_nxt  = '0;
    case (r_state)
      S_WAITING, S_WON, S_LOST: begin
        if (start_game) begin
          w_state_nxt   = S_SETUP;
          w_mask_nxt    = '0;
          w_strikes_nxt = '0;
        end
      end
      S_SETUP: begin
        // setup_complete beats the timeout when both land in the final cycle
        if (setup_complete) begin
          w_state_nxt = S_PLAYING;
        end else if (r_to_cnt == C_TO_LAST) begin
          w_state_nxt = S_WAITING;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
      end
      S_PLAYING: begin
        w_mask_nxt = w_solved_any;
        if (strike && (r_strikes != C_MAX_STRIKES)) begin
          w_strikes_nxt = r_strikes + 3'd1;
        end
        if (w_loss) begin
          w_state_nxt = S_LOST;
        end else if (w_win) begin
          w_state_nxt = S_WON;
        end else if (pause_toggle) begin
          w_state_nxt = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_toggle) begin
          w_state_nxt = S_PLAYING;
        end
      end
      default: w_state_nxt = S_WAITING;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_WAITING;
      r_mask        <= '0;
      r_strikes     <= '0;
      r_to_cnt      <= '0;
      r_begin_setup <= 1'b0;
      r_begin_timer <= 1'b0;
      r_timer_hold  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mask        <= w_mask_nxt;
      r_strikes     <= w_strikes_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      // Cues fire on state entry only, so held level inputs cannot retrigger them
      r_begin_setup <= (w_state_nxt == S_SETUP) && (r_state != S_SETUP);
      r_begin_timer <= (w_state_nxt == S_PLAYING) && (r_state == S_SETUP);
      r_timer_hold  <= (w_state_nxt == S_PAUSED);
    end
  end

  assign begin_setup  = r_begin_setup;
  assign begin_timer  = r_begin_timer;
  assign timer_hold   = r_timer_hold;
  assign solved_mask  = r_mask;
  assign strike_count = r_strikes;
  assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
// tb_game_sequencer : directed plus randomized checks against a game-rules model
// Revision 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_game_sequencer;

  localparam int NM  = 4;
  localparam int MS  = 3;
  localparam int STO = 8;

  localparam logic [2:0] M_WAIT  = 3'b000;
  localparam logic [2:0] M_SETUP = 3'b001;
  localparam logic [2:0] M_WON   = 3'b010;
  localparam logic [2:0] M_LOST  = 3'b011;
  localparam logic [2:0] M_PLAY  = 3'b100;
  localparam logic [2:0] M_PAUSE = 3'b101;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start_game, setup_complete, strike, timer_expired, pause_toggle;
  logic [NM-1:0] module_solved;
  logic          begin_setup, begin_timer, timer_hold;
  logic [NM-1:0] solved_mask;
  logic [2:0]    strike_count, state;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: game rules in plain terms
  logic [2:0]    m_state;
  logic [NM-1:0] m_mask;
  int            m_strikes;
  int            m_setup_age;
  logic          m_bs, m_bt, m_hold;

  game_sequencer #(
    .NUM_MODULES(NM), .MAX_STRIKES(MS), .SETUP_TIMEOUT(STO), .TO_W(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start_game(start_game),
    .setup_complete(setup_complete), .module_solved(module_solved),
    .strike(strike), .timer_expired(timer_expired), .pause_toggle(pause_toggle),
    .begin_setup(begin_setup), .begin_timer(begin_timer), .timer_hold(timer_hold),
    .solved_mask(solved_mask), .strike_count(strike_count), .state(state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_state = M_WAIT; m_mask = '0; m_strikes = 0; m_setup_age = 0;
    m_bs = 0; m_bt = 0; m_hold = 0;
  endtask

  task automatic model_step();
    logic [2:0] prev;
    logic lose, win;
    prev = m_state;
    case (prev)
      M_WAIT, M_WON, M_LOST:
        if (start_game) begin
          m_state = M_SETUP; m_mask = '0; m_strikes = 0; m_setup_age = 0;
        end
      M_SETUP: begin
        m_setup_age++;
        if (setup_complete) m_state = M_PLAY;
        else if (m_setup_age == STO) m_state = M_WAIT;
      end
      M_PLAY: begin
        lose = timer_expired || (strike && (m_strikes + 1 >= MS));
        m_mask = m_mask | module_solved;
        if (strike) m_strikes = (m_strikes + 1 > MS) ? MS : m_strikes + 1;
        win = (m_mask == {NM{1'b1}});
        if (lose) m_state = M_LOST;
        else if (win) m_state = M_WON;
        else if (pause_toggle) m_state = M_PAUSE;
      end
      M_PAUSE: if (pause_toggle) m_state = M_PLAY;
      default: m_state = M_WAIT;
    endcase
    if (m_state != M_SETUP) m_setup_age = 0;
    m_bs   = (m_state == M_SETUP) && (prev != M_SETUP);
    m_bt   = (m_state == M_PLAY) && (prev == M_SETUP);
    m_hold = (m_state == M_PAUSE);
  endtask

  task automatic compare_all(input string where);
    check({where, ".state"},  32'(state), 32'(m_state));
    check({where, ".mask"},   32'(solved_mask), 32'(m_mask));
    check({where, ".strikes"}, 32'(strike_count), 32'(m_strikes));
    check({where, ".cues"},   32'({begin_setup, begin_timer, timer_hold}), 32'({m_bs, m_bt, m_hold}));
  endtask

  task automatic step(input logic sg, input logic sc, input logic [NM-1:0] ms,
                      input logic st, input logic te, input logic pt, input string where);
    start_game = sg; setup_complete = sc; module_solved = ms;
    strike = st; timer_expired = te; pause_toggle = pt;
    @(posedge clock);
    model_step();
    #1;
    compare_all(where);
  endtask

  task automatic idle(input string where);
    step(0, 0, '0, 0, 0, 0, where);
  endtask

  task automatic go_playing(input string where);
    step(1, 0, '0, 0, 0, 0, where);
    step(0, 1, '0, 0, 0, 0, where);
  endtask

  // reset asserted between edges; outputs must clear before the next edge
  task automatic async_reset(input string where);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all(where);
    check({where, ".hold0"}, 32'(timer_hold), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    start_game = 0; setup_complete = 0; module_solved = '0;
    strike = 0; timer_expired = 0; pause_toggle = 0;
    model_reset();
    #12;
    compare_all("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle("post_reset");

    // basic win
    go_playing("win_setup");
    check("win_enter_play", 32'(state), 32'(3'b100));
    step(0, 0, 4'b0001, 0, 0, 0, "win_m0");
    step(0, 0, 4'b0010, 0, 0, 0, "win_m1");
    step(0, 0, 4'b0100, 0, 0, 0, "win_m2");
    step(0, 0, 4'b1000, 0, 0, 0, "win_m3");
    check("win_state", 32'(state), 32'(3'b010));
    check("win_mask", 32'(solved_mask), 32'hF);
    idle("win_hold");

    // strike loss and saturation
    go_playing("strk_setup");
    step(0, 0, '0, 1, 0, 0, "strk1");
    step(0, 0, '0, 1, 0, 0, "strk2");
    step(0, 0, '0, 1, 0, 0, "strk3");
    check("strk_lost", 32'({state, strike_count}), 32'({3'b011, 3'd3}));
    step(0, 0, '0, 1, 0, 0, "strk4");

    // simultaneous win and loss
    go_playing("sim_setup");
    step(0, 0, 4'b0111, 1, 0, 0, "sim_a");
    step(0, 0, '0, 1, 0, 0, "sim_b");
    step(0, 0, 4'b1000, 1, 0, 0, "sim_c");
    check("sim_lost", 32'(state), 32'(3'b011));

    // pause
    go_playing("pause_setup");
    step(0, 0, 4'b0001, 0, 0, 1, "pause_in");
    check("pause_hold", 32'({state, timer_hold}), 32'({3'b101, 1'b1}));
    step(0, 0, '0, 1, 0, 0, "pause_strike");
    step(0, 0, 4'b1111, 0, 0, 0, "pause_solve");
    step(1, 0, '0, 0, 1, 0, "pause_expire");
    step(0, 0, '0, 0, 0, 1, "pause_out");
    check("pause_resume", 32'({state, timer_hold}), 32'({3'b100, 1'b0}));

    // setup timeout and last-cycle completion
    step(0, 0, '0, 0, 1, 0, "to_lose");
    step(1, 0, '0, 0, 0, 0, "to_enter");
    for (int i = 0; i < STO; i++) idle("to_wait");
    check("to_abort", 32'(state), 32'(3'b000));
    step(1, 0, '0, 0, 0, 0, "to2_enter");
    for (int i = 0; i < STO - 1; i++) idle("to2_wait");
    step(0, 1, '0, 0, 0, 0, "to2_last");
    check("to2_play", 32'(state), 32'(3'b100));

    // async reset mid-game
    step(0, 0, 4'b0101, 1, 0, 0, "ar_a");
    step(0, 0, '0, 1, 0, 0, "ar_b");
    check("ar_pre", 32'({solved_mask, strike_count}), 32'({4'b0101, 3'd2}));
    async_reset("ar");
    idle("ar_post");

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      logic [NM-1:0] ms;
      ms = '0;
      for (int b = 0; b < NM; b++) ms[b] = ($urandom_range(99) < 6);
      if ($urandom_range(999) < 4) async_reset("rnd_rst");
      else step($urandom_range(99) < 10, $urandom_range(99) < 15, ms,
                $urandom_range(99) < 8, $urandom_range(999) < 15,
                $urandom_range(99) < 8, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Parametrised top-level game controller; successor to the single-module game state machine.
- Sequences WAITING -> SETUP -> PLAYING (with PAUSED) -> WON/LOST.
- Tracks per-module solve status across NUM_MODULES puzzle modules and counts strikes against a configurable limit.
- Pulses cues to the countdown timer and the bomb-logic modules, and exposes state to the visuals block.

Parameters:
- NUM_MODULES, 4, number of puzzle modules; legal range 1..16.
- MAX_STRIKES, 3, strikes that cause a loss; legal range 1..7.
- SETUP_TIMEOUT, 27000000, cycles allowed in SETUP before abort (1 s at 27 MHz); must be >= 2.
- TO_W, 25, width of the setup timeout counter; must satisfy 2^TO_W > SETUP_TIMEOUT.

Ports:
- clock  in  1  game clock, 27 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- start_game  in  1  level; user request to play.
- setup_complete  in  1  level; bomb setup finished.
- module_solved  in  NUM_MODULES  per-module solve pulses; one bit per module.
- strike  in  1  one-cycle pulse per wrong action (OR of all modules).
- timer_expired  in  1  level from the countdown timer.
- pause_toggle  in  1  one-cycle pulse; toggles between PLAYING and PAUSED.
- begin_setup  out  1  one-cycle pulse to bomb-logic.
- begin_timer  out  1  one-cycle pulse to the countdown timer.
- timer_hold  out  1  level; freezes the countdown timer.
- solved_mask  out  NUM_MODULES  sticky solved bits.
- strike_count  out  3  strikes so far.
- state  out  3  current state, for the visuals block and debug.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (reset_n).
- On reset assertion all outputs go to 0 immediately: state=WAITING, solved_mask=0, strike_count=0, timeout counter=0.
- All outputs are registered. No output is combinational from inputs.
- State encodings: WAITING=000, SETUP=001, WON=010, LOST=011, PLAYING=100, PAUSED=101. Bit 2 set means "in play" to the visuals block. Encodings 110 and 111 recover to WAITING on the next edge.
- WAITING:
  - When start_game=1 -> SETUP, with begin_setup=1 in the first SETUP cycle.
  - solved_mask and strike_count clear on this transition.
- SETUP:
  - The timeout counter increments each cycle.
  - setup_complete=1 -> PLAYING, with begin_timer=1 in the first PLAYING cycle and the counter cleared.
  - If the counter reaches SETUP_TIMEOUT-1 without setup_complete -> WAITING.
  - If setup_complete arrives in that same final cycle, setup_complete wins.
- PLAYING:
  - solved_mask <= solved_mask | module_solved.
  - A strike pulse increments strike_count, saturating at MAX_STRIKES.
  - Loss condition: timer_expired=1, or strike=1 while strike_count==MAX_STRIKES-1. Loss -> LOST.
  - Win condition: (solved_mask | module_solved) is all ones. Win -> WON.
  - If win and loss occur in the same cycle, LOST has priority.
  - pause_toggle=1 with no win or loss -> PAUSED; loss/win take priority over pause.
- PAUSED:
  - timer_hold=1.
  - module_solved and strike are ignored; mask and count are held.
  - timer_expired is ignored.
  - pause_toggle=1 -> PLAYING, and timer_hold drops in that PLAYING cycle.
  - start_game is ignored.
- WON / LOST:
  - solved_mask and strike_count are held for display.
  - start_game=1 -> SETUP with begin_setup=1; mask and count clear.
- Pulse outputs: begin_setup and begin_timer are exactly one cycle long. They do not repeat if the held level inputs remain high, because the cue is generated on the transition, not on the level.
- timer_hold: 1 only in PAUSED.
- strike_count: saturates, never wraps.
- Reset mid-game: any state returns asynchronously to WAITING with all outputs 0. No pulse is emitted on the release edge.

Test Plan:
- Basic win: reset_n low then high; start_game=1 -> state=001 and begin_setup high for 1 cycle. setup_complete=1 -> state=100 and begin_timer high for 1 cycle. Pulse module_solved=0001, 0010, 0100, 1000 on separate cycles -> state=010 one cycle after the last pulse; solved_mask=1111.
- Strike loss: in PLAYING, apply 3 strike pulses -> strike_count 1, 2, then state=011 with strike_count=3. A further strike leaves strike_count=3.
- Simultaneous win and loss: mask=0111 and strike_count=2; same cycle module_solved=1000 and strike=1 -> state=011.
- Pause: in PLAYING, pause_toggle -> state=101 and timer_hold=1. strike, module_solved and timer_expired during PAUSED leave count/mask/state unchanged. pause_toggle -> state=100 and timer_hold=0.
- Setup timeout: with SETUP_TIMEOUT=8, enter SETUP and hold setup_complete=0 -> state=000 after 8 SETUP cycles. Repeat with setup_complete asserted in cycle 8 -> state=100.
- Async reset: from PLAYING with mask=0101 and count=2, pulse reset_n low mid-cycle -> state=000, mask=0, count=0, timer_hold=0 before the next clock edge.
